// File: rtl/alu_issue.sv
// calc_pkg: shared number format for the calculator datapath.
//   num_t : 32-bit two's-complement Q16.16 fixed-point value.
package calc_pkg;
  typedef logic [31:0] num_t;
endpackage

// alu_issue: initiator-side front end for one single-outstanding ALU.
// Accepts an operand pair on the command port, issues it to the ALU,
// collects the result and returns it on the response port. A watchdog turns
// a hung ALU into an error response. Results that arrive while no command is
// waiting for them are drained and counted.
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   cmd_left_i/right_i/valid_i, cmd_ready_o   command port
//   left_o/right_o, alu_in_valid_o, alu_in_ready_i   ALU input handshake
//   alu_result_i, alu_out_valid_i, alu_out_ready_o   ALU output handshake
//   rsp_result_o/error_o/valid_o, rsp_ready_i  response port
//   stray_count_o                       saturating count of drained results
module alu_issue
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned STRAY_W        = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  num_t               cmd_left_i,
  input  num_t               cmd_right_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  output num_t               left_o,
  output num_t               right_o,
  output logic               alu_in_valid_o,
  input  logic               alu_in_ready_i,
  input  num_t               alu_result_i,
  input  logic               alu_out_valid_i,
  output logic               alu_out_ready_o,
  output num_t               rsp_result_o,
  output logic               rsp_error_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [STRAY_W-1:0] stray_count_o
);

  // Wide enough for the largest legal timeout limit.
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  num_t               left_q, left_d;
  num_t               right_q, right_d;
  num_t               rsp_result_q, rsp_result_d;
  logic               rsp_error_q, rsp_error_d;
  logic [STRAY_W-1:0] stray_q, stray_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               alu_in_valid_q, alu_in_valid_d;
  logic               alu_out_ready_q, alu_out_ready_d;
  logic               rsp_valid_q, rsp_valid_d;

  logic cmd_fire, in_fire, out_fire, rsp_fire, stray_fire;

  // Handshakes are judged against the registered ready/valid we present.
  assign cmd_fire = cmd_valid_i & cmd_ready_q;
  assign in_fire  = alu_in_valid_q & alu_in_ready_i;
  assign out_fire = alu_out_valid_i & alu_out_ready_q;
  assign rsp_fire = rsp_valid_q & rsp_ready_i;

  // Any result taken while no command is in WAIT is a stray.
  assign stray_fire = out_fire & ((state_q == S_IDLE) | (state_q == S_ISSUE));

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    left_d       = left_q;
    right_d      = right_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    stray_d      = stray_q;

    if (stray_fire && (stray_q != {STRAY_W{1'b1}})) begin
      stray_d = stray_q + STRAY_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          left_d  = cmd_left_i;
          right_d = cmd_right_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (in_fire) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result on the limit edge beats the watchdog.
        if (out_fire) begin
          rsp_result_d = alu_result_i;
          rsp_error_d  = 1'b0;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d = '0;
          rsp_error_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    cmd_ready_d     = (state_d == S_IDLE);
    alu_in_valid_d  = (state_d == S_ISSUE);
    alu_out_ready_d = (state_d != S_RESP);
    rsp_valid_d     = (state_d == S_RESP);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      left_q          <= '0;
      right_q         <= '0;
      rsp_result_q    <= '0;
      rsp_error_q     <= 1'b0;
      stray_q         <= '0;
      cmd_ready_q     <= 1'b1;
      alu_in_valid_q  <= 1'b0;
      alu_out_ready_q <= 1'b1;
      rsp_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      left_q          <= left_d;
      right_q         <= right_d;
      rsp_result_q    <= rsp_result_d;
      rsp_error_q     <= rsp_error_d;
      stray_q         <= stray_d;
      cmd_ready_q     <= cmd_ready_d;
      alu_in_valid_q  <= alu_in_valid_d;
      alu_out_ready_q <= alu_out_ready_d;
      rsp_valid_q     <= rsp_valid_d;
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign left_o          = left_q;
  assign right_o         = right_q;
  assign alu_in_valid_o  = alu_in_valid_q;
  assign alu_out_ready_o = alu_out_ready_q;
  assign rsp_result_o    = rsp_result_q;
  assign rsp_error_o     = rsp_error_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign stray_count_o   = stray_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Initiator-side front end for single-outstanding ALU units such as the adder. It accepts an operand pair from the calculator core over a ready/valid command port and issues it to the ALU's input handshake. It then collects the ALU result over the ALU's output handshake and returns it on a ready/valid response port. A watchdog converts a hung ALU into an error response, and results that arrive after a timeout are discarded and counted.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before an error response is produced. Legal range 2..65535.
- STRAY_W, default 8: width of the stray-result counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_left_i  in  calc_pkg::num_t  left operand.
- cmd_right_i  in  calc_pkg::num_t  right operand.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- left_o  out  calc_pkg::num_t  operand to the ALU's left_i.
- right_o  out  calc_pkg::num_t  operand to the ALU's right_i.
- alu_in_valid_o  out  1  drives the ALU's in_valid_i.
- alu_in_ready_i  in  1  from the ALU's in_ready_o.
- alu_result_i  in  calc_pkg::num_t  from the ALU's result_o.
- alu_out_valid_i  in  1  from the ALU's out_valid_o.
- alu_out_ready_o  out  1  drives the ALU's out_ready_i.
- rsp_result_o  out  calc_pkg::num_t  returned result.
- rsp_error_o  out  1  1 means timeout; rsp_result_o is then 0.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- stray_count_o  out  STRAY_W  saturating count of discarded ALU results.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - left_o, right_o, rsp_result_o = 0.
  - alu_in_valid_o, rsp_valid_o, rsp_error_o = 0.
  - stray_count_o = 0; timeout counter = 0.
  - cmd_ready_o = 1 and alu_out_ready_o = 1 after reset, because IDLE drives them.
- Handshakes: a transfer occurs on a rising edge where valid and ready are both 1. Once valid is asserted it holds, with stable data, until the transfer.
- IDLE:
  - cmd_ready_o = 1 and alu_out_ready_o = 1.
  - On a command transfer: register the operands into left_o/right_o and go to ISSUE.
- ISSUE:
  - alu_in_valid_o = 1, cmd_ready_o = 0, alu_out_ready_o = 1.
  - On an ALU input transfer: clear the counter and go to WAIT.
- WAIT:
  - alu_in_valid_o = 0, alu_out_ready_o = 1.
  - On an ALU output transfer: rsp_result_o <= alu_result_i, rsp_error_o <= 0, go to RESP.
  - Otherwise, if the counter equals TIMEOUT_CYCLES-1: rsp_result_o <= 0, rsp_error_o <= 1, go to RESP.
  - Otherwise the counter increments by 1.
- RESP:
  - rsp_valid_o = 1, alu_out_ready_o = 0.
  - On a response transfer: go to IDLE; rsp_valid_o drops the next cycle.
- Stray results:
  - Any ALU output transfer in IDLE or ISSUE is discarded.
  - Each discard increments stray_count_o, saturating at all-ones.
  - This drains a late result after a timeout, so the ALU never stalls the next issue.
- Simultaneous events:
  - In WAIT, a result transfer on the same edge the counter hits its limit wins: normal response, no error.
  - In ISSUE, a stray result transfer and an input transfer on the same edge are both processed: the stray is counted and the state moves to WAIT.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight command and its response are lost.
- Operands and results pass through bit-exact; the block does no arithmetic on num_t.

## Timing
- Command transfer at edge N: alu_in_valid_o = 1 during cycle N+1.
- ALU input accepted at edge N+1 (in_ready already high): result transfer at edge N+1+L for ALU latency L, and rsp_valid_o = 1 from that edge.
- Zero-wait total, command transfer to rsp_valid_o: L+1 edges.
- Back-to-back throughput is one command per L+3 cycles, with rsp_ready_i tied high.
- Timeout: with no result, rsp_valid_o with rsp_error_o = 1 rises TIMEOUT_CYCLES edges after the ALU input transfer.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- **Single add:** drive cmd left = num(1.5), right = num(2.25) into a real alu_add.
  - rsp_result_o == alu_model_pkg::num_add(left, right) == num(3.75).
  - rsp_error_o = 0; exactly one alu_in_valid_o transfer.
- **Response backpressure:** hold rsp_ready_i = 0 for 10 cycles.
  - rsp_valid_o and rsp_result_o stay stable.
  - cmd_ready_o = 0 and alu_out_ready_o = 0 throughout.
- **Timeout:** stub ALU never asserts alu_out_valid_i, TIMEOUT_CYCLES = 8.
  - Error response appears 8 edges after the input transfer, with rsp_result_o = 0.
  - Stub then returns a late result in IDLE: stray_count_o = 1, no response generated.
- **Race at limit:** stub asserts alu_out_valid_i exactly on the limit edge.
  - Normal response with rsp_error_o = 0.
- **Reset mid-WAIT:** pull rst_ni low for one cycle while in WAIT.
  - All outputs return to reset values asynchronously, before the next edge.
  - The next command completes normally.
- **Random soak:** 100000 random commands with random rsp_ready_i and random ALU stalls.
  - Every response matches the model.
  - stray_count_o stays 0 when no timeouts occur.
